ex_div: RTL
===========

EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-003 SHALL have port signed_div  input  1  1 = signed (two's complement) divide, 0 = unsigned.
REQ-004 SHALL have port opdata1  input  32  dividend.
REQ-005 SHALL have port opdata2  input  32  divisor.
REQ-006 SHALL have port start  input  1  EX-stage divide request; held high until result consumed.
REQ-007 SHALL have port annul  input  1  abort in-flight divide (pipeline flush).
REQ-008 SHALL have port result  output  64  {remainder[63:32], quotient[31:0]}.
REQ-009 SHALL have port ready  output  1  result valid.
REQ-010 SHALL have port stallreq  output  1  stall request toward the stall controller; drives stall[3:0] high, holding ID/EX and earlier stages.

Function
REQ-011 SHALL implement FSM states FREE, BYZERO, ON, END.
REQ-012 FREE: start=1 and annul=0 with opdata2==0 SHALL go to BYZERO; with opdata2!=0 SHALL go to ON, latching operands and clearing 6-bit counter cnt; otherwise SHALL stay in FREE.
REQ-013 At ON entry with signed_div=1, SHALL latch absolute values of negative operands and record both operand signs.
REQ-014 BYZERO SHALL go to END next edge with result 64'h0.
REQ-015 ON, cnt<32: SHALL perform one restoring step per cycle (shift 64-bit partial remainder left 1, compare upper 33 bits against {1'b0,divisor}, subtract and set quotient LSB when not less) and increment cnt.
REQ-016 ON, cnt==32: SHALL negate quotient if signed and operand signs differ, negate remainder if signed and dividend negative, register result, go to END.
REQ-017 ON with annul=1 SHALL go to FREE next edge, discarding work; result stays 64'h0, ready 0.
REQ-018 END SHALL hold ready=1 and result stable while start=1; start=0 SHALL return to FREE with ready=0, result=64'h0.
REQ-019 ready SHALL be 1 only in END; result SHALL be 64'h0 outside END.
REQ-020 stallreq SHALL equal start AND NOT ready (combinational), so the pipeline holds until END.
REQ-021 Latency: nonzero divisor, ready rises in cycle 34 after the edge sampling start in FREE; zero divisor, cycle 2.
REQ-022 Signed -2^31 / -1 SHALL return quotient 32'h8000_0000, remainder 0 (no trap).
REQ-023 Operand changes after ON entry SHALL be ignored.

Reset
REQ-024 rst=0 SHALL immediately force FREE, cnt=0, result=64'h0, ready=0, independent of clk.
REQ-025 Reset mid-division SHALL abandon the operation; no partial result SHALL appear after release.
REQ-026 After release, first start SHALL be accepted on the first rising edge.

Structure
REQ-027 State encodings (DivFree, DivByZero, DivOn, DivEnd), DivResultReady/NotReady, DivStart/DivStop SHALL live in the shared Defines.vh.
REQ-028 One combinational sub-module, div_step (one restoring iteration: 65-bit partial in, 65-bit partial out), SHALL be natural; FSM and registers stay in ex_div.

Verification
REQ-029 Unsigned 100/7, start held -> stallreq=1 for 34 cycles, ready in cycle 34, result {32'd2,32'd14}.
REQ-030 Signed -7/2 -> quotient 32'hFFFF_FFFD, remainder 32'hFFFF_FFFF; signed 32'h8000_0000/32'hFFFF_FFFF -> {0,32'h8000_0000}.
REQ-031 Divisor 0 -> ready in cycle 2, result 64'h0, stallreq drops with ready.
REQ-032 annul at cnt=10 -> FREE next edge, ready never asserted; new start 9/3 -> {0,3} after 34 cycles.
REQ-033 rst=0 asynchronously mid-ON (cnt=20) -> outputs zero same cycle; after release start 15/4 -> {3,3}.
REQ-034 Hold start 5 cycles in END -> result stable, ready=1; start=0 -> ready=0, result=0 next edge.

Source files
------------

// File: rtl/ex_div_pkg.sv
// Shared definitions for the EX-stage divider: FSM state encodings,
// ready/start levels and the operand width.
package ex_div_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    // Number of restoring iterations for a full-width quotient
    localparam logic [5:0] DivSteps = 6'd32;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration. The 65-bit partial holds the running
// remainder in the upper bits and the dividend/quotient bits in [31:0].
// A left shift exposes the next dividend bit; the upper 33 bits of the
// shifted value are trial-subtracted against the zero-extended divisor.
module div_step
    import ex_div_pkg::*;
(
    input  logic [2*DATA_W:0]  part,
    input  logic [DATA_W-1:0]  divisor,
    output logic [2*DATA_W:0]  part_next
);

    logic [DATA_W+1:0] diff;
    logic              ge;
    logic [DATA_W:0]   upper_new;

    // Trial subtraction on the shifted upper bits; the borrow bit decides
    always_comb begin
        diff      = part[2*DATA_W:DATA_W-1] - {2'b00, divisor};
        ge        = ~diff[DATA_W+1];
        upper_new = ge ? diff[DATA_W:0] : part[2*DATA_W-1:DATA_W-1];
        part_next = {upper_new, part[DATA_W-2:0], ge};
    end

endmodule

// File: rtl/ex_div.sv
// Multi-cycle 32-bit restoring divider for the EX stage. Holds the
// pipeline via stallreq until the result is ready, then keeps the result
// stable for as long as start stays high.
module ex_div
    import ex_div_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div,
    input  logic [DATA_W-1:0]   opdata1,
    input  logic [DATA_W-1:0]   opdata2,
    input  logic                start,
    input  logic                annul,
    output logic [2*DATA_W-1:0] result,
    output logic                ready,
    output logic                stallreq
);

    div_state_e          state;
    div_state_e          state_nxt;
    logic [5:0]          cnt;
    logic [2*DATA_W:0]   part;
    logic [2*DATA_W:0]   part_step;
    logic [DATA_W-1:0]   divisor;
    logic                neg_dvd;
    logic                neg_dvs;
    logic [2*DATA_W-1:0] result_q;
    logic                accept;

    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
        return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of a two's complement operand; -2^31 maps to 32'h8000_0000,
    // which is still correct when read as unsigned.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic            is_signed);
        logic signed [DATA_W-1:0] sv;
        sv = v;
        return (is_signed && (sv < 0)) ? negate(v) : v;
    endfunction

    div_step u_step (
        .part      (part),
        .divisor   (divisor),
        .part_next (part_step)
    );

    assign accept = (start == DivStart) && !annul;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= DivFree;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            DivFree: begin
                if (accept) state_nxt = (opdata2 == '0) ? DivByZero : DivOn;
            end
            DivByZero: state_nxt = DivEnd;
            DivOn: begin
                if (annul)                 state_nxt = DivFree;
                else if (cnt == DivSteps)  state_nxt = DivEnd;
            end
            DivEnd: begin
                if (start == DivStop) state_nxt = DivFree;
            end
            default: state_nxt = DivFree;
        endcase
    end

    // Outputs: ready only in END, result gated to zero elsewhere
    always_comb begin
        ready    = (state == DivEnd) ? DivResultReady : DivResultNotReady;
        result   = ready ? result_q : '0;
        stallreq = start & ~ready;
    end

    // Operand capture, iteration and result registration
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            part     <= '0;
            divisor  <= '0;
            neg_dvd  <= 1'b0;
            neg_dvs  <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                DivFree: begin
                    result_q <= '0;
                    if (accept && (opdata2 != '0)) begin
                        part    <= {{(DATA_W+1){1'b0}}, magnitude(opdata1, signed_div)};
                        divisor <= magnitude(opdata2, signed_div);
                        neg_dvd <= signed_div & opdata1[DATA_W-1];
                        neg_dvs <= signed_div & opdata2[DATA_W-1];
                        cnt     <= '0;
                    end
                end
                DivByZero: result_q <= '0;
                DivOn: begin
                    if (!annul) begin
                        if (cnt != DivSteps) begin
                            part <= part_step;
                            cnt  <= cnt + 6'd1;
                        end else begin
                            result_q[2*DATA_W-1:DATA_W] <= neg_dvd ? negate(part[2*DATA_W-1:DATA_W])
                                                                   : part[2*DATA_W-1:DATA_W];
                            result_q[DATA_W-1:0]        <= (neg_dvd ^ neg_dvs) ? negate(part[DATA_W-1:0])
                                                                               : part[DATA_W-1:0];
                        end
                    end
                end
                DivEnd: begin
                    if (start == DivStop) result_q <= '0;
                end
                default: result_q <= '0;
            endcase
        end
    end

endmodule
